// File: rtl/inst_fetch_pkg.sv
// Shared types and constants for the Buceros instruction-fetch stage.
package inst_fetch_pkg;

  localparam logic [31:0] ZERO_WORD   = 32'h0000_0000;
  localparam logic        NRST_ENABLE = 1'b0;
  localparam logic [31:0] NOP_INST    = 32'h0000_0013;

  typedef logic [31:0] addr_t;
  typedef logic [31:0] inst_t;

  typedef struct packed {
    addr_t pc;
    inst_t inst;
  } fetch_entry_t;

  function automatic addr_t align_word(input addr_t a);
    return a & ~32'h3;
  endfunction

  function automatic addr_t next_word(input addr_t a);
    return a + 32'd4;
  endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// Instruction-memory request/response bus between the fetch stage and memory.
interface inst_fetch_if
  import inst_fetch_pkg::*;
();
  logic  req_valid;
  logic  req_ready;
  addr_t req_addr;
  logic  resp_valid;
  inst_t resp_data;

  modport master (
    output req_valid, req_addr,
    input  req_ready, resp_valid, resp_data
  );

  modport slave (
    input  req_valid, req_addr,
    output req_ready, resp_valid, resp_data
  );
endinterface

// File: rtl/inst_fetch_fifo.sv
// Synchronous {pc,inst} buffer; head is read combinationally from storage.
module fetch_fifo
  import inst_fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wdata,
  output fetch_entry_t rdata,
  output logic [CW-1:0] count,
  output logic         empty,
  output logic         full
);
  fetch_entry_t  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  // Flush wins over both push and pop.
  assign w_push = push & ~flush & ~full;
  assign w_pop  = pop & ~flush & ~empty;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (nrst == NRST_ENABLE || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  assign rdata = r_mem[r_rd_ptr];
  assign count = r_count;
  assign empty = (r_count == '0);
  assign full  = (r_count == CW'(DEPTH));
endmodule

// File: rtl/inst_fetch.sv
// Buceros IF stage: fetch PC, credit-limited imem requests, redirect flush,
// and a small {pc,inst} buffer presented to the ID stage.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic         clk,
  input  logic         nrst,
  inst_fetch_if.master imem,
  input  logic         branch_i,
  input  logic [31:0]  branch_pc_i,
  input  logic         stall_i,
  output logic [31:0]  pc_o,
  output logic [31:0]  inst_o,
  output logic         inst_valid_o
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  addr_t         r_fetch_pc;
  addr_t         r_resp_pc;
  addr_t         r_pc_last;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_drop_cnt;

  logic [CW-1:0] w_fifo_count;
  logic          w_fifo_empty;
  logic          w_fifo_full;
  fetch_entry_t  w_fifo_head;
  fetch_entry_t  w_fifo_wdata;
  logic [CW:0]   w_in_use;
  logic          w_run;
  logic          w_credit_ok;
  logic          w_req_valid;
  logic          w_fire;
  logic          w_resp_ok;
  logic          w_drop;
  logic          w_push;
  logic          w_pop;
  addr_t         w_target;

  assign w_run    = (nrst != NRST_ENABLE);
  assign w_target = align_word(branch_pc_i);

  // Requests in flight plus buffered words never exceed the buffer size,
  // so every response always has a free slot waiting for it.
  assign w_in_use    = {1'b0, r_outstanding} + {1'b0, w_fifo_count};
  assign w_credit_ok = (w_in_use < (CW+1)'(FIFO_DEPTH));
  assign w_req_valid = w_run & ~branch_i & w_credit_ok;
  assign w_fire      = w_req_valid & imem.req_ready;

  assign w_resp_ok = imem.resp_valid & (r_outstanding != '0);
  assign w_drop    = w_resp_ok & (r_drop_cnt != '0);
  assign w_push    = w_resp_ok & ~w_drop & ~branch_i;
  assign w_pop     = ~w_fifo_empty & ~stall_i;

  assign w_fifo_wdata.pc   = r_resp_pc;
  assign w_fifo_wdata.inst = imem.resp_data;

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .nrst  (nrst),
    .push  (w_push),
    .pop   (w_pop),
    .flush (branch_i),
    .wdata (w_fifo_wdata),
    .rdata (w_fifo_head),
    .count (w_fifo_count),
    .empty (w_fifo_empty),
    .full  (w_fifo_full)
  );

  always_ff @(posedge clk) begin
    if (!w_run) begin
      r_fetch_pc    <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_pc_last     <= ZERO_WORD;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
    end else begin
      if (!w_fifo_empty) r_pc_last <= w_fifo_head.pc;
      if (branch_i) begin
        // Everything still in flight belongs to the old path; a response
        // arriving this very cycle is discarded along with the flush.
        r_fetch_pc    <= w_target;
        r_resp_pc     <= w_target;
        r_outstanding <= r_outstanding - CW'(w_resp_ok);
        r_drop_cnt    <= r_outstanding - CW'(w_resp_ok);
      end else begin
        if (w_fire) r_fetch_pc <= next_word(r_fetch_pc);
        if (w_push) r_resp_pc  <= next_word(r_resp_pc);
        r_outstanding <= r_outstanding + CW'(w_fire) - CW'(w_resp_ok);
        if (w_drop) r_drop_cnt <= r_drop_cnt - CW'(1);
      end
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (w_run) begin
      assert (!(imem.resp_valid && r_outstanding == '0))
        else $error("inst_fetch: response with no outstanding request");
      assert (!(w_push && w_fifo_full))
        else $error("inst_fetch: push into full fetch buffer");
    end
  end
`endif

  assign imem.req_valid = w_req_valid;
  assign imem.req_addr  = r_fetch_pc;

  assign inst_valid_o = ~w_fifo_empty;
  assign pc_o         = w_fifo_empty ? r_pc_last : w_fifo_head.pc;
  assign inst_o       = w_fifo_empty ? NOP_INST  : w_fifo_head.inst;
endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: memory model, epoch-based reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_inst_fetch;
  import inst_fetch_pkg::*;

  localparam int          DEPTH  = 2;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        branch_i = 1'b0;
  logic [31:0] branch_pc_i = 32'h0;
  logic        stall_i = 1'b0;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        inst_valid_o;

  inst_fetch_if imem();

  inst_fetch #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .nrst         (nrst),
    .imem         (imem),
    .branch_i     (branch_i),
    .branch_pc_i  (branch_pc_i),
    .stall_i      (stall_i),
    .pc_o         (pc_o),
    .inst_o       (inst_o),
    .inst_valid_o (inst_valid_o)
  );

  always #5 clk = ~clk;

  // Reference model: requests carry the redirect epoch they were issued in;
  // a response only reaches the buffer if its epoch is still current.
  typedef struct { logic [31:0] addr; int epoch; int due; } mreq_t;
  mreq_t       mem_q[$];
  logic [31:0] buf_q[$];
  logic [31:0] m_pc = RST_PC;
  logic [31:0] m_last_pc = 32'h0;
  int          m_epoch = 0;
  bit          m_known = 1'b0;
  int          cyc = 0;
  int          lat = 1;
  int          n_checks = 0;
  int          n_errors = 0;

  logic [31:0] acc_log[$];
  logic [31:0] pres_log[$];
  logic [31:0] pres_inst[$];

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] acc_at(input int i);
    if (i < acc_log.size()) return acc_log[i];
    return 'x;
  endfunction

  function automatic logic [31:0] pres_at(input int i);
    if (i < pres_log.size()) return pres_log[i];
    return 'x;
  endfunction

  function automatic logic [31:0] inst_at(input int i);
    if (i < pres_inst.size()) return pres_inst[i];
    return 'x;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Compare process: check outputs mid-cycle, then advance the model.
  always @(negedge clk) begin : cmp
    bit          exp_v;
    bit          do_pop;
    mreq_t       e;
    exp_v = 1'b0;
    if (m_known) begin
      exp_v = nrst && !branch_i && ((mem_q.size() + buf_q.size()) < DEPTH);
      check("req_valid", {31'b0, imem.req_valid}, {31'b0, exp_v});
      if (exp_v || !nrst) check("req_addr", imem.req_addr, m_pc);
      check("inst_valid", {31'b0, inst_valid_o}, {31'b0, (buf_q.size() > 0)});
      if (buf_q.size() > 0) begin
        check("pc", pc_o, buf_q[0]);
        check("inst", inst_o, mem_data(buf_q[0]));
      end else begin
        check("pc_hold", pc_o, m_last_pc);
        check("inst_nop", inst_o, NOP_INST);
      end
    end

    if (nrst && imem.req_valid && imem.req_ready) begin
      acc_log.push_back(imem.req_addr);
      $display("[%0d] fetch addr=%h", cyc, imem.req_addr);
    end
    if (nrst && inst_valid_o && !stall_i && !branch_i) begin
      pres_log.push_back(pc_o);
      pres_inst.push_back(inst_o);
      $display("[%0d] issue pc=%h inst=%h", cyc, pc_o, inst_o);
    end

    if (!nrst) begin
      mem_q.delete();
      buf_q.delete();
      m_pc      = RST_PC;
      m_last_pc = 32'h0;
      m_known   = 1'b1;
    end else begin
      if (buf_q.size() > 0) m_last_pc = buf_q[0];
      do_pop = (buf_q.size() > 0) && !stall_i;
      if (!branch_i && do_pop) void'(buf_q.pop_front());
      if (imem.resp_valid && mem_q.size() > 0) begin
        e = mem_q.pop_front();
        if (!branch_i && e.epoch == m_epoch) buf_q.push_back(e.addr);
      end
      if (branch_i) begin
        buf_q.delete();
        m_epoch++;
        m_pc = branch_pc_i & ~32'h3;
      end else if (exp_v && imem.req_ready) begin
        mem_q.push_back('{addr: m_pc, epoch: m_epoch, due: cyc + lat});
        m_pc = m_pc + 32'd4;
      end
    end
    cyc++;
  end

  task automatic drive_mem();
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      imem.resp_valid = 1'b1;
      imem.resp_data  = mem_data(mem_q[0].addr);
    end else begin
      imem.resp_valid = 1'b0;
      imem.resp_data  = 32'h0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    drive_mem();
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic clear_logs();
    acc_log.delete();
    pres_log.delete();
    pres_inst.delete();
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int  fv;
    bit  found;
    bit  seq_ok;
    imem.req_ready  = 1'b0;
    imem.resp_valid = 1'b0;
    imem.resp_data  = 32'h0;

    // Reset state
    run(3);
    @(negedge clk);
    check("rst_req_valid", {31'b0, imem.req_valid}, 32'd0);
    check("rst_req_addr", imem.req_addr, 32'h0000_0000);
    check("rst_inst_valid", {31'b0, inst_valid_o}, 32'd0);
    check("rst_inst", inst_o, 32'h0000_0013);
    check("rst_pc", pc_o, 32'h0000_0000);

    // Zero-wait memory, latency 1
    tick();
    clear_logs();
    nrst = 1'b1;
    imem.req_ready = 1'b1;
    lat = 1;
    fv = -1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (fv < 0 && inst_valid_o) fv = i;
      tick();
    end
    check("first_valid_cycle", fv, 32'd2);
    check("first_req", acc_at(0), 32'h0000_0000);
    check("second_req", acc_at(1), 32'h0000_0004);
    check("third_req", acc_at(2), 32'h0000_0008);
    check("first_issue_pc", pres_at(0), 32'h0000_0000);
    check("first_issue_inst", inst_at(0), 32'h1357_9BDF);

    // Stall 5 cycles: buffer fills, requests stop
    stall_i = 1'b1;
    run(4);
    @(negedge clk);
    check("stall_req_valid", {31'b0, imem.req_valid}, 32'd0);
    check("stall_inst_valid", {31'b0, inst_valid_o}, 32'd1);
    tick();
    stall_i = 1'b0;
    run(10);
    seq_ok = (pres_log.size() >= 8);
    for (int i = 1; i < pres_log.size(); i++)
      if (pres_log[i] != pres_log[i-1] + 32'd4) seq_ok = 1'b0;
    check("pc_order_after_stall", {31'b0, seq_ok}, 32'd1);

    // Redirect with two requests outstanding
    lat = 3;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      tick();
      if (mem_q.size() == 2) found = 1'b1;
    end
    check("wait_two_outstanding", {31'b0, found}, 32'd1);
    clear_logs();
    branch_i = 1'b1;
    branch_pc_i = 32'h0000_0103;
    tick();
    branch_i = 1'b0;
    run(15);
    check("redirect_first_req", acc_at(0), 32'h0000_0100);
    check("redirect_first_pc", pres_at(0), 32'h0000_0100);
    check("redirect_second_pc", pres_at(1), 32'h0000_0104);

    // Redirect in the same cycle as a response and a pop
    lat = 1;
    run(6);
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      tick();
      if (imem.resp_valid && buf_q.size() > 0 && !stall_i) found = 1'b1;
    end
    check("wait_resp_and_pop", {31'b0, found}, 32'd1);
    clear_logs();
    branch_i = 1'b1;
    branch_pc_i = 32'h0000_0200;
    tick();
    branch_i = 1'b0;
    @(negedge clk);
    check("flush_inst_valid", {31'b0, inst_valid_o}, 32'd0);
    tick();
    run(10);
    check("flush_first_pc", pres_at(0), 32'h0000_0200);

    // Ready low for 4 cycles with a redirect in the second
    nrst = 1'b0;
    run(2);
    nrst = 1'b1;
    imem.req_ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (m_pc == 32'h8 && (mem_q.size() + buf_q.size()) < DEPTH) found = 1'b1;
    end
    check("wait_addr_8", {31'b0, found}, 32'd1);
    imem.req_ready = 1'b0;
    @(negedge clk);
    check("nready_valid_c1", {31'b0, imem.req_valid}, 32'd1);
    check("nready_addr_c1", imem.req_addr, 32'h0000_0008);
    tick();
    branch_i = 1'b1;
    branch_pc_i = 32'h0000_0040;
    @(negedge clk);
    check("nready_valid_c2", {31'b0, imem.req_valid}, 32'd0);
    tick();
    branch_i = 1'b0;
    @(negedge clk);
    check("nready_valid_c3", {31'b0, imem.req_valid}, 32'd1);
    check("nready_addr_c3", imem.req_addr, 32'h0000_0040);
    tick();
    @(negedge clk);
    check("nready_addr_c4", imem.req_addr, 32'h0000_0040);
    tick();
    imem.req_ready = 1'b1;
    run(8);

    // Address wrap
    clear_logs();
    branch_i = 1'b1;
    branch_pc_i = 32'hFFFF_FFF8;
    tick();
    branch_i = 1'b0;
    run(12);
    check("wrap_req0", acc_at(0), 32'hFFFF_FFF8);
    check("wrap_req1", acc_at(1), 32'hFFFF_FFFC);
    check("wrap_req2", acc_at(2), 32'h0000_0000);
    check("wrap_pc2", pres_at(2), 32'h0000_0000);

    // One-cycle reset mid-stream
    nrst = 1'b0;
    tick();
    nrst = 1'b1;
    @(negedge clk);
    check("rerst_req_valid", {31'b0, imem.req_valid}, 32'd1);
    check("rerst_req_addr", imem.req_addr, 32'h0000_0000);
    check("rerst_inst_valid", {31'b0, inst_valid_o}, 32'd0);
    check("rerst_inst", inst_o, 32'h0000_0013);
    tick();
    run(10);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
